// File: rtl/vend_credit_controller.sv
// Vending credit engine: accumulates dime/quarter credit, arbitrates select/cancel/timeout,
// and sequences the dispense and 5-cent change handshakes.
module vend_credit_controller #(
    parameter int PRICE      = 50,
    parameter int MAX_CREDIT = 95,
    parameter int CW         = 7,
    parameter int TIMEOUT    = 200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_in,
    input  logic          q_in,
    input  logic          sel,
    input  logic          cancel,
    input  logic          vend_ack,
    input  logic          chg_ack,
    output logic          vend_req,
    output logic          chg_req,
    output logic          coin_reject,
    output logic [CW-1:0] credit,
    output logic          busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW:0]   MAX_X   = (CW+1)'(MAX_CREDIT);
    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [CW-1:0] UNIT    = CW'(5);

    typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] credit_n, remain;
    logic [TW-1:0] tmo, tmo_n;
    logic          reject_n, accepted, coin_ok;
    logic [CW:0]   sum_q, sum_d;

    // Sums carry one extra bit so a coin near the top of the range cannot wrap.
    assign sum_q   = {1'b0, credit} + (CW+1)'(25);
    assign sum_d   = {1'b0, credit} + (CW+1)'(10);
    assign remain  = credit - PRICE_C;
    assign coin_ok = (state == IDLE) || (state == ACCUM);

    always_comb begin
        state_n  = state;
        credit_n = credit;
        tmo_n    = '0;
        reject_n = 1'b0;
        accepted = 1'b0;

        // Quarter has priority; a simultaneous dime is always bounced.
        if (d_in || q_in) begin
            if (!coin_ok) begin
                reject_n = 1'b1;
            end else if (q_in) begin
                if (sum_q > MAX_X) reject_n = 1'b1;
                else begin
                    credit_n = sum_q[CW-1:0];
                    accepted = 1'b1;
                end
                if (d_in) reject_n = 1'b1;
            end else begin
                if (sum_d > MAX_X) reject_n = 1'b1;
                else begin
                    credit_n = sum_d[CW-1:0];
                    accepted = 1'b1;
                end
            end
        end

        case (state)
            IDLE: begin
                if (accepted) state_n = ACCUM;
            end
            ACCUM: begin
                // sel qualifies on registered credit only, ignoring a same-cycle coin.
                if (sel && credit >= PRICE_C)       state_n = VEND;
                else if (cancel)                    state_n = CHANGE;
                else if (d_in || q_in || sel)       tmo_n   = '0;
                else if (tmo == TW'(TIMEOUT - 1))   state_n = CHANGE;
                else                                tmo_n   = tmo + TW'(1);
            end
            VEND: begin
                if (vend_ack) begin
                    credit_n = remain;
                    state_n  = (remain != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (credit == '0) state_n = IDLE;
                else if (chg_ack) begin
                    credit_n = credit - UNIT;
                    if (credit == UNIT) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            tmo         <= '0;
            coin_reject <= 1'b0;
            vend_req    <= 1'b0;
            chg_req     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            tmo         <= tmo_n;
            coin_reject <= reject_n;
            vend_req    <= (state_n == VEND);
            chg_req     <= (state_n == CHANGE);
            busy        <= (state_n == VEND) || (state_n == CHANGE);
        end
    end
endmodule

// File: tb/tb_vend_credit_controller.sv
// Directed scoreboard bench for vend_credit_controller: each step queues the expected
// outputs for the following edge and checks them 1 time unit after that edge.
module tb_vend_credit_controller;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_in = 1'b0, q_in = 1'b0, sel = 1'b0, cancel = 1'b0;
    logic       vend_ack = 1'b0, chg_ack = 1'b0;
    logic       vend_req, chg_req, coin_reject, busy;
    logic [6:0] credit;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       vr;
        logic       cr;
        logic       rej;
        logic       bz;
        logic [6:0] cred;
        string      tag;
    } exp_t;

    exp_t sb[$];

    vend_credit_controller #(.PRICE(50), .MAX_CREDIT(95), .CW(7), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .q_in(q_in), .sel(sel), .cancel(cancel),
        .vend_ack(vend_ack), .chg_ack(chg_ack), .vend_req(vend_req), .chg_req(chg_req),
        .coin_reject(coin_reject), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish within budget");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic vr, cr, rej, bz, input int cred, input string tag);
        exp_t e;
        e.vr = vr; e.cr = cr; e.rej = rej; e.bz = bz; e.cred = 7'(cred); e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        tests++;
        assert ({vend_req, chg_req, coin_reject, busy, credit} === {e.vr, e.cr, e.rej, e.bz, e.cred})
        else begin
            fails++;
            $error("FAIL %s: observed vr=%0b cr=%0b rej=%0b busy=%0b credit=%0d, expected vr=%0b cr=%0b rej=%0b busy=%0b credit=%0d",
                   e.tag, vend_req, chg_req, coin_reject, busy, credit, e.vr, e.cr, e.rej, e.bz, e.cred);
        end
    endtask

    // One clock of stimulus {d,q,sel,cancel,vack,cack} and the outputs expected after its edge.
    task automatic cyc(input logic d, q, s, c, va, ca,
                       input logic vr, cr, rej, bz, input int cred, input string tag);
        @(negedge clk);
        d_in = d; q_in = q; sel = s; cancel = c; vend_ack = va; chg_ack = ca;
        push(vr, cr, rej, bz, cred, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle_in();
        @(negedge clk);
        d_in = 0; q_in = 0; sel = 0; cancel = 0; vend_ack = 0; chg_ack = 0;
    endtask

    initial begin
        // Reset state
        idle_in();
        rst = 1'b1;
        push(0, 0, 0, 0, 0, "reset");
        #1;
        check_out();
        idle_in();
        rst = 1'b0;

        // Exact-price vend, ack after 3 cycles of vend_req
        cyc(0,1,0,0,0,0, 0,0,0,0,25, "t1 q1");
        cyc(0,1,0,0,0,0, 0,0,0,0,50, "t1 q2");
        cyc(0,0,1,0,0,0, 1,0,0,1,50, "t1 sel");
        cyc(0,0,0,0,0,0, 1,0,0,1,50, "t1 wait1");
        cyc(0,0,0,0,0,0, 1,0,0,1,50, "t1 wait2");
        cyc(0,0,0,0,1,0, 0,0,0,0,0,  "t1 ack");
        cyc(0,0,0,0,0,0, 0,0,0,0,0,  "t1 idle");

        // Vend with 25c change, chg_ack held high
        cyc(0,1,0,0,0,0, 0,0,0,0,25, "t2 q1");
        cyc(0,1,0,0,0,0, 0,0,0,0,50, "t2 q2");
        cyc(0,1,0,0,0,0, 0,0,0,0,75, "t2 q3");
        cyc(0,0,1,0,0,0, 1,0,0,1,75, "t2 sel");
        cyc(0,0,0,0,1,0, 0,1,0,1,25, "t2 vack");
        for (int k = 1; k <= 5; k++)
            cyc(0,0,0,0,0,1, 0,(k < 5),0,(k < 5),25 - 5*k, "t2 chg");
        cyc(0,0,0,0,0,1, 0,0,0,0,0, "t2 stray ack");

        // Fill to MAX_CREDIT, then overflow rejected
        cyc(0,1,0,0,0,0, 0,0,0,0,25, "t3 q1");
        cyc(0,1,0,0,0,0, 0,0,0,0,50, "t3 q2");
        cyc(0,1,0,0,0,0, 0,0,0,0,75, "t3 q3");
        cyc(1,0,0,0,0,0, 0,0,0,0,85, "t3 d1");
        cyc(1,0,0,0,0,0, 0,0,0,0,95, "t3 d2");
        cyc(0,1,0,0,0,0, 0,0,1,0,95, "t3 reject");
        cyc(0,0,0,0,0,0, 0,0,0,0,95, "t3 rej pulse");
        cyc(0,0,0,1,0,0, 0,1,0,1,95, "t3 cancel");
        for (int k = 1; k <= 19; k++)
            cyc(0,0,0,0,0,1, 0,(k < 19),0,(k < 19),95 - 5*k, "t3 chg");

        // Dime+quarter together, sel below price, cancel
        cyc(1,1,0,0,0,0, 0,0,1,0,25, "t4 dq");
        cyc(0,0,1,0,0,0, 0,0,0,0,25, "t4 sel low");
        cyc(0,0,0,1,0,0, 0,1,0,1,25, "t4 cancel");
        for (int k = 1; k <= 5; k++)
            cyc(0,0,0,0,0,1, 0,(k < 5),0,(k < 5),25 - 5*k, "t4 chg");
        cyc(0,0,0,0,1,0, 0,0,0,0,0, "t4 stray vack");

        // Timeout refund exactly TO cycles after the coin edge
        cyc(0,1,0,0,0,0, 0,0,0,0,25, "t5 q");
        for (int k = 1; k < TO; k++)
            cyc(0,0,0,0,0,0, 0,0,0,0,25, "t5 wait");
        cyc(0,0,0,0,0,0, 0,1,0,1,25, "t5 timeout");
        for (int k = 1; k <= 5; k++)
            cyc(0,0,0,0,0,1, 0,(k < 5),0,(k < 5),25 - 5*k, "t5 chg");

        // Coin during VEND rejected, then async reset mid-VEND
        cyc(0,1,0,0,0,0, 0,0,0,0,25, "t6 q1");
        cyc(0,1,0,0,0,0, 0,0,0,0,50, "t6 q2");
        cyc(0,0,1,0,0,0, 1,0,0,1,50, "t6 sel");
        cyc(1,0,0,0,0,0, 1,0,1,1,50, "t6 coin in vend");
        idle_in();
        rst = 1'b1;
        push(0, 0, 0, 0, 0, "t6 async rst");
        #1;
        check_out();
        idle_in();
        rst = 1'b0;
        cyc(0,1,0,0,0,0, 0,0,0,0,25, "t6 q after rst");
        cyc(0,0,0,1,0,0, 0,1,0,1,25, "t6 cancel");
        for (int k = 1; k <= 5; k++)
            cyc(0,0,0,0,0,1, 0,(k < 5),0,(k < 5),25 - 5*k, "t6 chg");
        idle_in();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vend_credit_controller.md
# vend_credit_controller

Sequencing controller for the coin-operated vending datapath: accumulates credit from dime and quarter coin pulses, arbitrates select/cancel/timeout, drives the product dispenser through a req/ack handshake, then pays out remaining credit as 5-cent change units through a second req/ack handshake. It sits between the coin acceptor/keypad front end and the dispense and change-hopper mechanisms, replacing fixed-price hard-wired vend logic with a parameterised credit engine.

## Interface
- PRICE, 50: product price in cents; must be a multiple of 5 and ≤ MAX_CREDIT
- MAX_CREDIT, 95: highest credit accepted, in cents; multiple of 5, < 2^CW
- CW, 7: credit register width
- TIMEOUT, 200: idle cycles in ACCUM before automatic refund; ≥ 2
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- d_in  in  1  dime (10¢) inserted, one-cycle pulse
- q_in  in  1  quarter (25¢) inserted, one-cycle pulse
- sel  in  1  product select, one-cycle pulse
- cancel  in  1  refund request, one-cycle pulse
- vend_ack  in  1  dispenser done; sampled only while vend_req=1
- chg_ack  in  1  one 5¢ unit paid out; sampled only while chg_req=1
- vend_req  out  1  dispense request, level
- chg_req  out  1  change payout request, level
- coin_reject  out  1  one-cycle pulse: coin returned, not credited
- credit  out  CW  current credit in cents
- busy  out  1  high in VEND or CHANGE

## Operation
- States: IDLE (credit=0), ACCUM, VEND, CHANGE. All outputs registered.
- Coin acceptance in IDLE/ACCUM only: new = credit + 10 (d_in) or + 25 (q_in). If new > MAX_CREDIT, coin rejected (coin_reject pulse, credit unchanged). Accepted coin in IDLE moves to ACCUM.
- d_in and q_in in the same cycle: quarter evaluated first; dime always rejected that cycle.
- Coins in VEND or CHANGE: always rejected.
- sel in ACCUM with credit ≥ PRICE (credit after any same-cycle coin is NOT considered; uses registered credit) -> VEND, vend_req=1. sel with credit < PRICE, or in any other state: ignored.
- VEND: hold vend_req until vend_ack; on ack, credit -= PRICE, vend_req=0; next state CHANGE if remainder > 0, else IDLE.
- cancel in ACCUM -> CHANGE. cancel in IDLE/VEND/CHANGE ignored. cancel and sel same cycle: sel wins if it qualifies, else cancel.
- Timeout counter: cleared on entering ACCUM and on any coin (accepted or rejected) or sel; counts in ACCUM; reaching TIMEOUT -> CHANGE.
- CHANGE: chg_req=1 while credit > 0; each cycle with chg_ack: credit -= 5. Credit reaching 0 -> chg_req=0, IDLE.
- Credit is always a multiple of 5; no underflow possible.
- coin_reject pulses are independent of state transitions and may coincide with them.

## Timing
- Reset values: state IDLE, credit=0, vend_req=0, chg_req=0, coin_reject=0, busy=0, timeout counter 0.
- Reset asserted mid-VEND or mid-CHANGE: request drops immediately (async), credit lost; documented, not recovered.
- Coin pulse at edge N -> credit/coin_reject updated after edge N (visible cycle N+1).
- sel sampled at edge N -> vend_req=1, busy=1 from cycle N+1.
- vend_ack sampled at edge M -> vend_req=0 and credit reduced from M+1; chg_req=1 from M+1 if remainder > 0.
- chg_ack back-to-back every cycle is legal: one unit per cycle. Last ack -> chg_req=0, busy=0 next cycle.
- Timeout: with no activity, CHANGE entered exactly TIMEOUT cycles after the last coin/sel edge.
- vend_ack or chg_ack while corresponding req=0: ignored.

## Test plan
- Reset, q_in ×2, sel, vend_ack after 3 cycles -> vend_req high 3 cycles, credit 50 -> 0, IDLE, no chg_req.
- q_in ×3 (75), sel, vend_ack, chg_ack held high -> credit 25 after vend, chg_req for exactly 5 acks, credit 0, IDLE.
- q_in ×3, d_in, d_in, q_in -> credits 25,50,75,85,95, then 6th coin rejected (coin_reject pulse, credit stays 95).
- d_in and q_in same cycle from IDLE -> credit 25, coin_reject 1 cycle; sel at credit 25 ignored; cancel -> 5 change units.
- q_in once, then no activity -> CHANGE exactly TIMEOUT cycles later, 5 units paid, IDLE.
- q_in ×2, sel, assert rst during VEND -> vend_req, credit, busy 0 immediately; q_in after release accepted normally.
